// File: rtl/mops_sdo_responder_pkg.sv
// Shared types and constants for the MOPS-side CANopen SDO responder.
// Frame layout: [75:65] COB-ID, [64] RTR, [63:0] bytes 0..7 with byte0 in the top byte.
package mops_sdo_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        DECODE,
        ADC_WAIT,
        DELAY,
        SEND
    } sdo_state_t;

    typedef enum logic [1:0] {
        FRAME_BOOT,
        FRAME_UPLOAD,
        FRAME_ABORT
    } frame_kind_t;

    localparam int FRAME_W  = 76;
    localparam int COB_MSB  = 75;
    localparam int COB_LSB  = 65;
    localparam int RTR_BIT  = 64;
    localparam int DATA_MSB = 63;

    localparam logic [10:0] COB_REQ_BASE  = 11'h600;
    localparam logic [10:0] COB_RESP_BASE = 11'h580;
    localparam logic [10:0] COB_BOOT_BASE = 11'h700;

    localparam logic [15:0] ADC_INDEX = 16'h2400;

    localparam logic [7:0] CS_UPLOAD_REQ  = 8'h40;
    localparam logic [7:0] CS_UPLOAD_RESP = 8'h43;
    localparam logic [7:0] CS_ABORT       = 8'h80;

    localparam logic [31:0] ABORT_BAD_CS      = 32'h0504_0001;
    localparam logic [31:0] ABORT_NO_OBJECT   = 32'h0602_0000;
    localparam logic [31:0] ABORT_BAD_SUB     = 32'h0609_0011;
    localparam logic [31:0] ABORT_ADC_TIMEOUT = 32'h0800_0000;

    function automatic logic [10:0] cob_id(input logic [10:0] base, input logic [6:0] node);
        return base + {4'h0, node};
    endfunction

    function automatic logic [7:0] data_byte(input logic [63:0] data, input int n);
        return data[DATA_MSB - 8*n -: 8];
    endfunction

endpackage

// File: rtl/mops_sdo_responder_if.sv
// Request/response frame bus plus ADC sample handshake of one SDO responder.
interface mops_sdo_responder_if;
    import mops_sdo_pkg::*;

    logic [FRAME_W-1:0] rx_frame;
    logic               rx_valid;
    logic [FRAME_W-1:0] tx_frame;
    logic               tx_valid;
    logic               tx_ready;
    logic               adc_req;
    logic [5:0]         adc_sel;
    logic [11:0]        adc_data;
    logic               adc_ack;
    logic               busy;
    logic               rx_drop;

    modport slave (
        input  rx_frame, rx_valid, tx_ready, adc_data, adc_ack,
        output tx_frame, tx_valid, adc_req, adc_sel, busy, rx_drop
    );

    modport master (
        output rx_frame, rx_valid, tx_ready, adc_data, adc_ack,
        input  tx_frame, tx_valid, adc_req, adc_sel, busy, rx_drop
    );

endinterface

// File: rtl/mops_sdo_responder_frame_builder.sv
// Combinational packing of boot-up, upload and abort frames from latched request fields.
module sdo_frame_builder
    import mops_sdo_pkg::*;
#(
    parameter logic [6:0] NODE_ID = 7'h00
) (
    input  frame_kind_t        kind,
    input  logic [15:0]        index,
    input  logic [7:0]         sub,
    input  logic [11:0]        adc_data,
    input  logic [31:0]        abort_code,
    output logic [FRAME_W-1:0] frame
);

    logic [7:0]  byte_arr [8];
    logic [10:0] cob;
    logic [63:0] data;

    always_comb begin
        cob = cob_id(COB_RESP_BASE, NODE_ID);
        for (int i = 0; i < 8; i++) begin
            byte_arr[i] = 8'h00;
        end
        case (kind)
            FRAME_BOOT: begin
                cob = cob_id(COB_BOOT_BASE, NODE_ID);
            end
            FRAME_UPLOAD: begin
                byte_arr[0] = CS_UPLOAD_RESP;
                byte_arr[1] = index[7:0];
                byte_arr[2] = index[15:8];
                byte_arr[3] = sub;
                byte_arr[4] = adc_data[7:0];
                byte_arr[5] = {4'h0, adc_data[11:8]};
            end
            FRAME_ABORT: begin
                byte_arr[0] = CS_ABORT;
                byte_arr[1] = index[7:0];
                byte_arr[2] = index[15:8];
                byte_arr[3] = sub;
                byte_arr[4] = abort_code[7:0];
                byte_arr[5] = abort_code[15:8];
                byte_arr[6] = abort_code[23:16];
                byte_arr[7] = abort_code[31:24];
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
            assign data[DATA_MSB - 8*gi -: 8] = byte_arr[gi];
        end
    endgenerate

    assign frame = {cob, 1'b0, data};

endmodule

// File: rtl/mops_sdo_responder.sv
// MOPS-side SDO responder: boot-up after reset, ADC upload answers or abort frames
// released a fixed delay after request acceptance.
module mops_sdo_responder
    import mops_sdo_pkg::*;
#(
    parameter logic [6:0]  NODE_ID     = 7'h00,
    parameter logic [5:0]  N_ADC       = 6'd35,
    parameter logic [7:0]  RESP_DELAY  = 8'd16,
    parameter logic [11:0] ADC_TIMEOUT = 12'd1024
) (
    input logic                clk_40_m,
    input logic                rst,
    mops_sdo_responder_if.slave sdo
);

    sdo_state_t         state_reg;
    logic               tx_valid_reg;
    logic [FRAME_W-1:0] tx_frame_reg;
    logic               adc_req_reg;
    logic [5:0]         adc_sel_reg;
    logic               busy_reg;
    logic               rx_drop_reg;
    logic [7:0]         cs_reg;
    logic [15:0]        index_reg;
    logic [7:0]         sub_reg;
    logic [11:0]        adc_data_reg;
    logic               abort_reg;
    logic [31:0]        abort_code_reg;
    logic [7:0]         dly_cnt_reg;
    logic [11:0]        to_cnt_reg;

    logic               rx_match;
    logic               dly_done;
    frame_kind_t        frame_kind;
    logic [FRAME_W-1:0] built_frame;

    assign rx_match = sdo.rx_valid
                   && (sdo.rx_frame[COB_MSB:COB_LSB] == cob_id(COB_REQ_BASE, NODE_ID))
                   && !sdo.rx_frame[RTR_BIT];

    // dly_cnt_reg holds the number of edges since the accepting edge minus one
    assign dly_done = (dly_cnt_reg >= RESP_DELAY - 8'd1);

    assign frame_kind = (state_reg == BOOT) ? FRAME_BOOT
                      : (abort_reg ? FRAME_ABORT : FRAME_UPLOAD);

    sdo_frame_builder #(
        .NODE_ID (NODE_ID)
    ) u_frame_builder (
        .kind       (frame_kind),
        .index      (index_reg),
        .sub        (sub_reg),
        .adc_data   (adc_data_reg),
        .abort_code (abort_code_reg),
        .frame      (built_frame)
    );

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state_reg      <= BOOT;
            tx_valid_reg   <= 1'b0;
            tx_frame_reg   <= '0;
            adc_req_reg    <= 1'b0;
            adc_sel_reg    <= '0;
            busy_reg       <= 1'b0;
            rx_drop_reg    <= 1'b0;
            cs_reg         <= '0;
            index_reg      <= '0;
            sub_reg        <= '0;
            adc_data_reg   <= '0;
            abort_reg      <= 1'b0;
            abort_code_reg <= '0;
            dly_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
        end else begin
            rx_drop_reg <= rx_match && (state_reg != IDLE);
            if (dly_cnt_reg != 8'hFF) begin
                dly_cnt_reg <= dly_cnt_reg + 8'd1;
            end

            case (state_reg)
                BOOT: begin
                    if (tx_valid_reg && sdo.tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        busy_reg <= 1'b1;
                        if (!tx_valid_reg) begin
                            tx_valid_reg <= 1'b1;
                            tx_frame_reg <= built_frame;
                        end
                    end
                end

                IDLE: begin
                    busy_reg <= 1'b0;
                    if (rx_match) begin
                        cs_reg         <= data_byte(sdo.rx_frame[DATA_MSB:0], 0);
                        index_reg      <= {data_byte(sdo.rx_frame[DATA_MSB:0], 2),
                                           data_byte(sdo.rx_frame[DATA_MSB:0], 1)};
                        sub_reg        <= data_byte(sdo.rx_frame[DATA_MSB:0], 3);
                        adc_data_reg   <= '0;
                        abort_reg      <= 1'b0;
                        abort_code_reg <= '0;
                        dly_cnt_reg    <= '0;
                        busy_reg       <= 1'b1;
                        state_reg      <= DECODE;
                    end
                end

                DECODE: begin
                    state_reg <= DELAY;
                    if (cs_reg != CS_UPLOAD_REQ) begin
                        abort_reg      <= 1'b1;
                        abort_code_reg <= ABORT_BAD_CS;
                    end else if (index_reg != ADC_INDEX) begin
                        abort_reg      <= 1'b1;
                        abort_code_reg <= ABORT_NO_OBJECT;
                    end else if (sub_reg >= {2'b00, N_ADC}) begin
                        abort_reg      <= 1'b1;
                        abort_code_reg <= ABORT_BAD_SUB;
                    end else begin
                        adc_req_reg <= 1'b1;
                        adc_sel_reg <= sub_reg[5:0];
                        to_cnt_reg  <= '0;
                        state_reg   <= ADC_WAIT;
                    end
                end

                ADC_WAIT: begin
                    // an ack arriving on the timeout cycle still counts as a sample
                    if (sdo.adc_ack) begin
                        adc_data_reg <= sdo.adc_data;
                        adc_req_reg  <= 1'b0;
                        state_reg    <= DELAY;
                    end else if (to_cnt_reg >= ADC_TIMEOUT - 12'd1) begin
                        adc_req_reg    <= 1'b0;
                        abort_reg      <= 1'b1;
                        abort_code_reg <= ABORT_ADC_TIMEOUT;
                        state_reg      <= DELAY;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 12'd1;
                    end
                end

                DELAY: begin
                    if (dly_done) begin
                        tx_valid_reg <= 1'b1;
                        tx_frame_reg <= built_frame;
                        state_reg    <= SEND;
                    end
                end

                SEND: begin
                    if (sdo.tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end

                default: begin
                    state_reg <= BOOT;
                end
            endcase
        end
    end

    assign sdo.tx_frame = tx_frame_reg;
    assign sdo.tx_valid = tx_valid_reg;
    assign sdo.adc_req  = adc_req_reg;
    assign sdo.adc_sel  = adc_sel_reg;
    assign sdo.busy     = busy_reg;
    assign sdo.rx_drop  = rx_drop_reg;

endmodule

// File: tb/tb_mops_sdo_responder.sv
// Randomised self-checking bench for mops_sdo_responder against a byte-level SDO model.
module tb_mops_sdo_responder;

    localparam logic [6:0]  NODE       = 7'h00;
    localparam logic [5:0]  NADC       = 6'd35;
    localparam logic [7:0]  RDLY       = 8'd16;
    localparam logic [11:0] ATO        = 12'd1024;
    localparam logic [10:0] REQ_COB    = 11'h600 + {4'h0, NODE};
    localparam logic [10:0] RESP_COB   = 11'h580 + {4'h0, NODE};
    localparam logic [10:0] BOOT_COB   = 11'h700 + {4'h0, NODE};

    logic clk_40_m = 1'b0;
    logic rst      = 1'b0;
    int   cyc      = 0;
    int   tests    = 0;
    int   fails    = 0;
    int   txn      = 0;

    mops_sdo_responder_if sdo ();

    mops_sdo_responder #(
        .NODE_ID     (NODE),
        .N_ADC       (NADC),
        .RESP_DELAY  (RDLY),
        .ADC_TIMEOUT (ATO)
    ) dut (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .sdo      (sdo.slave)
    );

    always #5 clk_40_m = ~clk_40_m;
    always @(posedge clk_40_m) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_40_m);
        #1;
    endtask

    // abort code the request deserves before any ADC access; 0 means upload
    function automatic logic [31:0] model_abort(input logic [7:0] cs, input logic [15:0] idx,
                                                input logic [7:0] sub);
        if (cs != 8'h40)            return 32'h05040001;
        if (idx != 16'h2400)        return 32'h06020000;
        if (int'(sub) >= int'(NADC)) return 32'h06090011;
        return 32'h0;
    endfunction

    function automatic logic [75:0] model_frame(input logic [15:0] idx, input logic [7:0] sub,
                                                input logic [11:0] adc, input logic [31:0] code);
        logic [7:0]  b [8];
        logic [63:0] d;
        b[1] = idx[7:0];
        b[2] = idx[15:8];
        b[3] = sub;
        if (code == 32'h0) begin
            b[0] = 8'h43;
            b[4] = adc[7:0];
            b[5] = {4'h0, adc[11:8]};
            b[6] = 8'h00;
            b[7] = 8'h00;
        end else begin
            b[0] = 8'h80;
            b[4] = code[7:0];
            b[5] = code[15:8];
            b[6] = code[23:16];
            b[7] = code[31:24];
        end
        d = '0;
        for (int i = 0; i < 8; i++) d = {d[55:0], b[i]};
        return {RESP_COB, 1'b0, d};
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // ack_dly: number of adc_req-high cycles before acking; 0 withholds the ack
    task automatic run_req(input logic [7:0] cs, input logic [15:0] idx, input logic [7:0] sub,
                           input int ack_dly, input logic [11:0] adc_val,
                           input bit hold, input bit dup);
        logic [31:0] code;
        logic [75:0] snap;
        int          e0, eack, exp_rise, rise, req_cycles;
        bit          got_rise, dup_pending, stable;
        code = model_abort(cs, idx, sub);
        sdo.tx_ready = !hold;
        sdo.rx_frame = {REQ_COB, 1'b0, cs, idx[7:0], idx[15:8], sub, 32'h0};
        sdo.rx_valid = 1'b1;
        step();
        sdo.rx_valid = 1'b0;
        e0 = cyc;
        eack = 0; rise = 0; req_cycles = 0;
        got_rise = 0; dup_pending = 0;
        for (int k = 0; k < 3000 && !got_rise; k++) begin
            step();
            sdo.adc_ack  = 1'b0;
            sdo.rx_valid = 1'b0;
            if (dup_pending) begin
                chk("rx_drop", sdo.rx_drop, 1);
                dup_pending = 0;
            end
            if (sdo.tx_valid) begin
                got_rise = 1;
                rise = cyc;
            end else if (sdo.adc_req) begin
                req_cycles++;
                if (req_cycles == 1) chk("adc_sel", sdo.adc_sel, sub[5:0]);
                if (ack_dly > 0 && req_cycles == ack_dly) begin
                    sdo.adc_ack  = 1'b1;
                    sdo.adc_data = adc_val;
                    eack = cyc + 1;
                end
                if (dup && req_cycles == 5) begin
                    sdo.rx_frame = {REQ_COB, 1'b0, 8'h40, 8'h00, 8'h24, sub ^ 8'h01, 32'h0};
                    sdo.rx_valid = 1'b1;
                    dup_pending  = 1;
                end
            end
        end
        if (code != 32'h0) begin
            chk("no_adc_req", req_cycles, 0);
            exp_rise = imax(e0 + int'(RDLY), e0 + 2);
        end else if (ack_dly > 0) begin
            exp_rise = imax(e0 + int'(RDLY), eack + 1);
        end else begin
            chk("adc_req_len", req_cycles, int'(ATO));
            code = 32'h08000000;
            exp_rise = imax(e0 + int'(RDLY), e0 + 1 + int'(ATO) + 1);
        end
        chk("tx_rise_seen", got_rise, 1);
        chk("tx_rise_cycle", rise - e0, exp_rise - e0);
        chk("tx_frame", sdo.tx_frame, model_frame(idx, sub, adc_val, code));
        if (hold) begin
            snap = sdo.tx_frame;
            stable = 1;
            repeat (50) begin
                step();
                if (sdo.tx_frame !== snap || !sdo.tx_valid) stable = 0;
            end
            chk("hold_stable", stable, 1);
            sdo.tx_ready = 1'b1;
        end
        step();
        chk("tx_released", sdo.tx_valid, 0);
        chk("idle_busy", sdo.busy, 0);
        txn++;
        $display("[TB] txn %0d cs=%h idx=%h sub=%h ack_dly=%0d hold=%0d dup=%0d resp=%h",
                 txn, cs, idx, sub, ack_dly, hold, dup, snap_or(sdo.tx_frame));
    endtask

    function automatic logic [75:0] snap_or(input logic [75:0] f);
        return f;
    endfunction

    initial begin
        logic [7:0]  r_cs, r_sub;
        logic [15:0] r_idx;
        int          kind, seen, vcount;

        sdo.rx_frame = '0;
        sdo.rx_valid = 1'b0;
        sdo.tx_ready = 1'b1;
        sdo.adc_data = '0;
        sdo.adc_ack  = 1'b0;
        repeat (3) step();
        chk("rst_tx_valid", sdo.tx_valid, 0);
        chk("rst_tx_frame", sdo.tx_frame, 0);
        chk("rst_busy", sdo.busy, 0);
        chk("rst_adc_req", sdo.adc_req, 0);

        rst = 1'b1;
        step();
        chk("boot_valid", sdo.tx_valid, 1);
        chk("boot_frame", sdo.tx_frame, {BOOT_COB, 1'b0, 64'h0});
        step();
        chk("boot_done_valid", sdo.tx_valid, 0);
        chk("boot_done_busy", sdo.busy, 0);
        $display("[TB] txn boot-up frame checked");

        run_req(8'h40, 16'h2400, 8'h05, 3, 12'hABC, 0, 0);
        chk("upload_literal", model_frame(16'h2400, 8'h05, 12'hABC, 32'h0),
            {11'h580, 1'b0, 64'h43002405BC0A0000});
        run_req(8'h40, 16'h2401, 8'h00, 3, 12'h123, 0, 0);
        run_req(8'h40, 16'h2400, 8'd35, 3, 12'h123, 0, 0);
        run_req(8'h40, 16'h2400, 8'd34, 2, 12'hFFF, 0, 0);
        run_req(8'h23, 16'h2400, 8'h01, 3, 12'h123, 0, 0);
        run_req(8'h40, 16'h2400, 8'h07, 0, 12'h000, 0, 1);
        run_req(8'h40, 16'h2400, 8'h02, 30, 12'h5A5, 1, 0);

        for (int n = 0; n < 12; n++) begin
            kind  = $urandom_range(0, 5);
            r_cs  = 8'h40;
            r_idx = 16'h2400;
            r_sub = 8'($urandom_range(0, int'(NADC) - 1));
            if (kind == 0) begin
                r_cs = 8'($urandom_range(0, 255));
                if (r_cs == 8'h40) r_cs = 8'h41;
            end else if (kind == 1) begin
                r_idx = 16'($urandom);
                if (r_idx == 16'h2400) r_idx = 16'h2402;
            end else if (kind == 2) begin
                r_sub = 8'($urandom_range(int'(NADC), 255));
            end
            run_req(r_cs, r_idx, r_sub, $urandom_range(1, 30), 12'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end

        // foreign COB-ID and RTR frames must be ignored
        sdo.rx_frame = {REQ_COB + 11'd1, 1'b0, 64'h4000240100000000};
        sdo.rx_valid = 1'b1;
        step();
        sdo.rx_frame = {REQ_COB, 1'b1, 64'h4000240100000000};
        step();
        sdo.rx_valid = 1'b0;
        chk("ignore_busy", sdo.busy, 0);
        vcount = 0;
        repeat (25) begin
            step();
            if (sdo.tx_valid) vcount++;
        end
        chk("ignore_no_tx", vcount, 0);
        $display("[TB] txn ignored foreign and RTR frames");

        // reset during ADC wait: abort silently, then only the boot-up frame
        sdo.rx_frame = {REQ_COB, 1'b0, 64'h4000240900000000};
        sdo.rx_valid = 1'b1;
        step();
        sdo.rx_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            step();
            if (sdo.adc_req) seen = 1;
        end
        chk("mid_adc_req_seen", seen, 1);
        rst = 1'b0;
        step();
        chk("mid_rst_adc_req", sdo.adc_req, 0);
        chk("mid_rst_tx_valid", sdo.tx_valid, 0);
        rst = 1'b1;
        step();
        chk("reboot_valid", sdo.tx_valid, 1);
        chk("reboot_frame", sdo.tx_frame, {BOOT_COB, 1'b0, 64'h0});
        step();
        vcount = 0;
        repeat (40) begin
            step();
            if (sdo.tx_valid || sdo.adc_req) vcount++;
        end
        chk("reboot_quiet", vcount, 0);
        $display("[TB] txn reset during ADC wait");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mops_sdo_responder.md
Name: mops_sdo_responder

Overview:
- Synthesisable MOPS-side CANopen SDO responder, clocked on clk_40_m; the responding end of the MOPSHUB SDO traffic on one bus.
- Accepts decoded 76-bit request frames and sends a boot-up frame after reset.
- Answers ADC upload requests by fetching a sample through an ADC request/ack handshake, and emits 76-bit response frames.
- Replaces the behavioural MOPS emulation in per-bus testbench data generators; one instance per bus.

Parameters:
NODE_ID, 7'h00, CANopen node ID; request COB-ID = 11'h600+NODE_ID, response = 11'h580+NODE_ID, boot-up = 11'h700+NODE_ID
N_ADC, 6'd35, number of valid ADC subindices (0..N_ADC-1) under index 16'h2400
RESP_DELAY, 8'd16, clk_40_m cycles between request acceptance and response valid (min 1)
ADC_TIMEOUT, 12'd1024, cycles to wait for adc_ack before aborting

Ports:
clk_40_m  in  1  clock
rst  in  1  reset, synchronous, active-low
rx_frame  in  76  request frame: [75:65] COB-ID, [64] RTR, [63:0] bytes 0..7 (byte0 at [63:56])
rx_valid  in  1  one-cycle strobe, rx_frame valid
tx_frame  out  76  response frame, same format, RTR=0
tx_valid  out  1  response valid; held until tx_ready
tx_ready  in  1  consumer accepts tx_frame when tx_valid&&tx_ready
adc_req  out  1  ADC sample request, held until adc_ack
adc_sel  out  6  ADC channel = request subindex
adc_data  in  12  sample, valid with adc_ack
adc_ack  in  1  one-cycle sample acknowledge
busy  out  1  high in every state except IDLE
rx_drop  out  1  one-cycle pulse when a matching request arrives while busy

Behaviour:
- Reset (rst==0 at clk_40_m edge): all outputs and registers 0, state BOOT.
- Reset mid-operation aborts any transaction; no partial frame is emitted. Boot-up is re-sent.
- BOOT: tx_frame={11'h700+NODE_ID,1'b0,64'h0}, tx_valid=1; on handshake go to IDLE.
- IDLE: on rx_valid, with COB-ID==600+NODE_ID and RTR==0, latch cs=byte0, index={byte2,byte1}, sub=byte3; go to DECODE next cycle. Other COB-IDs and RTR frames are ignored silently.
- DECODE (1 cycle):
  - cs!=8'h40 → abort code 32'h05040001
  - index!=16'h2400 → abort 32'h06020000
  - sub>=N_ADC → abort 32'h06090011
  - otherwise → ADC_WAIT
  - Abort cases go to DELAY.
- ADC_WAIT: adc_req=1, adc_sel=sub[5:0], timeout counter increments.
  - adc_ack → latch adc_data, adc_req=0, go to DELAY.
  - Counter reaches ADC_TIMEOUT-1 without ack → adc_req=0, abort 32'h08000000, go to DELAY.
  - adc_ack in the same cycle as timeout: ack wins.
- DELAY: counter starts at acceptance. tx_valid rises exactly RESP_DELAY cycles after the IDLE cycle that sampled rx_valid, or after ADC ack/timeout if that is later.
- SEND: tx_valid=1 and tx_frame stable until handshake, then IDLE. tx_ready may already be high when tx_valid rises (same-cycle transfer allowed).
- Upload response bytes 0..7: 43, idx_lo, idx_hi, sub, adc[7:0], {4'h0,adc[11:8]}, 00, 00.
- Abort response bytes 0..7: 80, idx_lo, idx_hi, sub, code[7:0], code[15:8], code[23:16], code[31:24]; index/sub echo the request.
- Matching rx_valid in any state other than IDLE: frame discarded, rx_drop pulses for 1 cycle, transaction in progress is unaffected.
- Counters saturate; no wrap-around.

Decomposition:
- Package mops_sdo_pkg:
  - state enum {BOOT, IDLE, DECODE, ADC_WAIT, DELAY, SEND}
  - COB-ID bases 11'h600/11'h580/11'h700
  - ADC_INDEX 16'h2400
  - SDO command specifiers 8'h40/8'h43/8'h80
  - abort-code constants
  - frame field offsets
- One natural sub-module: sdo_frame_builder (combinational packing of upload/abort/boot-up frames from latched fields).

Test Plan:
- Release reset, tx_ready=1 → tx_valid on first cycle after reset, tx_frame[75:65]=11'h700, data 64'h0; then busy=0.
- Request 11'h600, bytes 40 00 24 05 00.., adc_ack after 3 cycles with adc_data=12'hABC → adc_sel=5, response 11'h580, bytes 43 00 24 05 BC 0A 00 00, tx_valid exactly 16 cycles after request.
- Request index 2401 sub 0 → abort bytes 80 01 24 00 00 00 02 06; adc_req never asserted.
- Request sub=35 (N_ADC=35) → abort code 06090011. Request cs=8'h23 → abort code 05040001.
- adc_ack withheld → adc_req drops after 1024 cycles, abort code 08000000. Second request while waiting → rx_drop pulse and first response unchanged.
- tx_ready held low for 50 cycles → tx_frame stable. Assert rst during ADC_WAIT → adc_req=0 next cycle, then boot-up frame only.
